systolic_tile: RTL
==================

// Module: systolic_tile
// PURPOSE
//   Output-stationary N1xN2 MAC tile that computes C = A*B over a runtime inner dimension K.
//   Input and output streams use valid/ready handshakes, and input skew is generated internally.
//   Sits between the A/B operand buffers and the result writer.
//   Successor to the fixed-M array: adds runtime K, bubble tolerance, backpressured drain,
//   optional signedness and optional saturation.
// PARAMETERS
//   D_W      8   operand width
//   D_W_ACC  16  accumulator / result width
//   N1       4   tile rows (A lanes, D lanes)
//   N2       4   tile cols (B lanes, drain beats)
//   K_MAX    64  maximum inner dimension
//   SIGNED   0   1: operands/accumulators two's complement; 0: unsigned
// PORTS
//   clk       in   1                    clock
//   rst       in   1                    async active-high reset
//   start     in   1                    begin job; sampled in IDLE only
//   cfg_k     in   $clog2(K_MAX+1)      inner dimension, latched on start
//   busy      out  1                    high in any state other than IDLE
//   in_valid  in   1                    A/B beat valid
//   in_ready  out  1                    high in LOAD
//   A         in   [D_W-1:0] x N1       beat k: A[i] = Amat[i][k]
//   B         in   [D_W-1:0] x N2       beat k: B[j] = Bmat[k][j]
//   D         out  [D_W_ACC-1:0] x N1   drain beat j: D[i] = C[i][j]
//   d_valid   out  1                    result beat valid
//   d_ready   in   1                    result beat accept
//   d_col     out  $clog2(N2) (min 1)   column index of current beat
//   d_last    out  1                    d_valid && d_col==N2-1
//   done      out  1                    1-cycle pulse after last drain beat accepted
//   ovf       out  1                    sticky overflow for current job
// BEHAVIOUR
// - Reset (async): state=IDLE; all accumulators, skew registers and counters=0.
//   All outputs 0; in_ready=0.
// - FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
//   * IDLE: on start, latch cfg_k and clear accumulators and ovf. Next state is LOAD,
//     or FLUSH if cfg_k==0. start outside IDLE is ignored.
//   * LOAD: in_ready=1. Handshake = in_valid&&in_ready; each handshake increments k_cnt.
//     Leave for FLUSH in the cycle after the handshake with k_cnt==cfg_k-1.
//     No handshake in a cycle -> zeros are injected (bubble); result is unaffected.
//   * FLUSH: zeros injected for exactly N1+N2-1 cycles, then DRAIN.
//   * DRAIN: d_valid=1, d_col starts at 0. On d_valid&&d_ready, d_col increments.
//     After the beat with d_col==N2-1 is accepted, go to IDLE and pulse done.
//     D and d_col hold stable while d_ready=0.
// - Datapath:
//   * Operands are registered on entry.
//   * Row i of A is delayed i cycles; column j of B is delayed j cycles.
//   * The array shifts every cycle in LOAD and FLUSH; it is frozen in IDLE and DRAIN.
//   * PE(i,j): acc += a*b. Full 2*D_W product, sign-extended if SIGNED=1, else zero-extended,
//     then added modulo 2^D_W_ACC.
// - cfg_k > K_MAX: clamped to K_MAX. cfg_k==0: all results 0.
// - Reset asserted mid-job: immediate abort, with no partial done or d_valid.
// CONFIGURATION
// - SYSTOLIC_SAT_EN defined:
//   * Each accumulation saturates to the representable range: [0, 2^D_W_ACC-1] unsigned,
//     signed min/max if SIGNED=1.
//   * ovf sets on any clamp in the job, holds until next start, clears on reset.
// - SYSTOLIC_SAT_EN undefined: wrap-around arithmetic; ovf tied 0.
// TESTING
// 1. Identity: K=4, A=I4, B rows {1..16} -> D columns equal B columns; 4 beats, d_col 0..3; done once.
// 2. Bubbles: test 1 with in_valid toggled every other cycle -> identical D; in_ready high only in LOAD.
// 3. Backpressure: d_ready=0 for 3 cycles on beat 1 -> D and d_col stable; no beat lost or repeated.
// 4. Overflow, unsigned, K=2, all operands 255:
//    without SYSTOLIC_SAT_EN -> D=0xFC02, ovf=0; with it -> D=0xFFFF, ovf=1.
// 5. Signed: SIGNED=1, K=4, A=-1, B=127 -> every D=0xFE04 (-508).
// 6. Reset mid-LOAD, after 2 beats -> busy, in_ready, d_valid drop to 0 at once;
//    a fresh K=1 job with A=B=3 gives D=9.

Source files
------------

// File: rtl/systolic_tile.sv
// systolic_tile: output-stationary N1xN2 MAC tile computing C = A*B over a runtime inner dimension.
// Define SYSTOLIC_SAT_EN for saturating accumulation with a sticky per-job ovf flag.
module systolic_tile #(
   parameter int D_W     = 8,
   parameter int D_W_ACC = 16,
   parameter int N1      = 4,
   parameter int N2      = 4,
   parameter int K_MAX   = 64,
   parameter int SIGNED  = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [$clog2(K_MAX+1)-1:0]            cfg_k,
   output logic                                  busy,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [N1-1:0][D_W-1:0]                A,
   input  logic [N2-1:0][D_W-1:0]                B,
   output logic [N1-1:0][D_W_ACC-1:0]            D,
   output logic                                  d_valid,
   input  logic                                  d_ready,
   output logic [((N2 > 1) ? $clog2(N2) : 1)-1:0] d_col,
   output logic                                  d_last,
   output logic                                  done,
   output logic                                  ovf
);

   localparam int KW = $clog2(K_MAX+1);
   localparam int CW = (N2 > 1) ? $clog2(N2) : 1;
   localparam int FW = $clog2(N1+N2);
   localparam int WW = ((D_W_ACC > 2*D_W) ? D_W_ACC : 2*D_W) + 2;

`ifdef SYSTOLIC_SAT_EN
   localparam logic signed [WW-1:0] ONE_X   = WW'(1);
   localparam logic signed [WW-1:0] SAT_MAX = (SIGNED != 0) ? (ONE_X <<< (D_W_ACC-1)) - ONE_X
                                                            : (ONE_X <<< D_W_ACC) - ONE_X;
   localparam logic signed [WW-1:0] SAT_MIN = (SIGNED != 0) ? -(ONE_X <<< (D_W_ACC-1)) : '0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_cfg_q, k_cfg_d;
   logic [KW-1:0] k_cnt_q, k_cnt_d;
   logic [FW-1:0] fl_cnt_q, fl_cnt_d;
   logic [CW-1:0] col_q, col_d;
   logic          done_q, done_d;
   logic          ovf_q;
   logic          clr, shift_en, hs, ovf_hit;

   logic [D_W-1:0]     a_in  [N1];
   logic [D_W-1:0]     b_in  [N2];
   logic [D_W-1:0]     a_pe  [N1][N2];
   logic [D_W-1:0]     b_pe  [N1][N2];
   logic [D_W_ACC-1:0] acc_q [N1][N2];
   logic [D_W_ACC-1:0] acc_d [N1][N2];

   // Returns {clamped, acc + a*b}; the flag can only be set when saturation is built in.
   function automatic logic [D_W_ACC:0] mac_f(input logic [D_W_ACC-1:0] acc,
                                              input logic [D_W-1:0]     a,
                                              input logic [D_W-1:0]     b);
      logic signed [WW-1:0] acc_x, prod_x, sum_x;
      logic [2*D_W-1:0]     prod;
      if (SIGNED != 0) begin
         prod   = $signed({{D_W{a[D_W-1]}}, a}) * $signed({{D_W{b[D_W-1]}}, b});
         acc_x  = {{(WW-D_W_ACC){acc[D_W_ACC-1]}}, acc};
         prod_x = {{(WW-2*D_W){prod[2*D_W-1]}}, prod};
      end else begin
         prod   = {{D_W{1'b0}}, a} * {{D_W{1'b0}}, b};
         acc_x  = {{(WW-D_W_ACC){1'b0}}, acc};
         prod_x = {{(WW-2*D_W){1'b0}}, prod};
      end
      sum_x = acc_x + prod_x;
`ifdef SYSTOLIC_SAT_EN
      if (sum_x > SAT_MAX) return {1'b1, SAT_MAX[D_W_ACC-1:0]};
      if (sum_x < SAT_MIN) return {1'b1, SAT_MIN[D_W_ACC-1:0]};
`endif
      return {1'b0, sum_x[D_W_ACC-1:0]};
   endfunction

   always_comb begin
      state_d  = state_q;
      k_cfg_d  = k_cfg_q;
      k_cnt_d  = k_cnt_q;
      fl_cnt_d = fl_cnt_q;
      col_d    = col_q;
      done_d   = 1'b0;
      clr      = 1'b0;
      hs       = (state_q == S_LOAD) && in_valid;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               clr      = 1'b1;
               k_cfg_d  = (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;
               k_cnt_d  = '0;
               fl_cnt_d = '0;
               col_d    = '0;
               state_d  = (cfg_k == '0) ? S_FLUSH : S_LOAD;
            end
         end
         S_LOAD: begin
            if (hs) begin
               k_cnt_d = k_cnt_q + KW'(1);
               if (k_cnt_q == k_cfg_q - KW'(1)) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            fl_cnt_d = fl_cnt_q + FW'(1);
            if (fl_cnt_q == FW'(N1+N2-2)) begin
               fl_cnt_d = '0;
               col_d    = '0;
               state_d  = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (d_ready) begin
               if (col_q == CW'(N2-1)) begin
                  col_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         k_cfg_q  <= '0;
         k_cnt_q  <= '0;
         fl_cnt_q <= '0;
         col_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_cfg_q  <= k_cfg_d;
         k_cnt_q  <= k_cnt_d;
         fl_cnt_q <= fl_cnt_d;
         col_q    <= col_d;
         done_q   <= done_d;
      end
   end

   // Entry stage: a cycle without a handshake injects zeros so bubbles leave the sums untouched.
   assign shift_en = (state_q == S_LOAD) || (state_q == S_FLUSH);

   always_comb begin
      for (int i = 0; i < N1; i++) a_in[i] = hs ? A[i] : '0;
      for (int j = 0; j < N2; j++) b_in[j] = hs ? B[j] : '0;
   end

   // Skew + operand shift: element 0 is the entry register, PE(i,j) reads element i+j.
   for (genvar i = 0; i < N1; i++) begin : g_row
      logic [D_W-1:0] line_q [i+N2];
      always_ff @(posedge clk or posedge rst) begin
         if (rst || clr) begin
            for (int p = 0; p < i+N2; p++) line_q[p] <= '0;
         end else if (shift_en) begin
            line_q[0] <= a_in[i];
            for (int p = 1; p < i+N2; p++) line_q[p] <= line_q[p-1];
         end
      end
      for (genvar j = 0; j < N2; j++) begin : g_tap
         assign a_pe[i][j] = line_q[i+j];
      end
   end

   for (genvar j = 0; j < N2; j++) begin : g_col
      logic [D_W-1:0] line_q [j+N1];
      always_ff @(posedge clk or posedge rst) begin
         if (rst || clr) begin
            for (int p = 0; p < j+N1; p++) line_q[p] <= '0;
         end else if (shift_en) begin
            line_q[0] <= b_in[j];
            for (int p = 1; p < j+N1; p++) line_q[p] <= line_q[p-1];
         end
      end
      for (genvar i = 0; i < N1; i++) begin : g_tap
         assign b_pe[i][j] = line_q[j+i];
      end
   end

   // MAC stage: accumulators stay in place and only advance while the array shifts.
   always_comb begin
      logic [D_W_ACC:0] r;
      r       = '0;
      ovf_hit = 1'b0;
      for (int i = 0; i < N1; i++) begin
         for (int j = 0; j < N2; j++) begin
            r           = mac_f(acc_q[i][j], a_pe[i][j], b_pe[i][j]);
            acc_d[i][j] = r[D_W_ACC-1:0];
            ovf_hit     = ovf_hit | r[D_W_ACC];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || clr) begin
         for (int i = 0; i < N1; i++)
            for (int j = 0; j < N2; j++) acc_q[i][j] <= '0;
         ovf_q <= 1'b0;
      end else if (shift_en) begin
         for (int i = 0; i < N1; i++)
            for (int j = 0; j < N2; j++) acc_q[i][j] <= acc_d[i][j];
         if (ovf_hit) ovf_q <= 1'b1;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign in_ready = (state_q == S_LOAD);
   assign d_valid  = (state_q == S_DRAIN);
   assign d_col    = col_q;
   assign d_last   = d_valid && (col_q == CW'(N2-1));
   assign done     = done_q;
   assign ovf      = ovf_q;

   always_comb begin
      for (int i = 0; i < N1; i++) D[i] = d_valid ? acc_q[i][col_q] : '0;
   end

endmodule
